// File: rtl/sat_round_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sat_round_pipe_pkg
//   Shared defaults and helpers for the sat_round_pipe block.
//   - Default widths: ISZ (input sample), OSZ (output sample), NCH
//     (channels), SHW (shift control), CNTW (saturation counter).
//   - sat_limit(): signed OSZ-bit max or min value.
//   - ch_lsb():    lsb index of a channel slice in a packed multi-channel bus.
// ---------------------------------------------------------------------------
package sat_round_pipe_pkg;

    localparam int ISZ_DEF  = 17;
    localparam int OSZ_DEF  = 12;
    localparam int NCH_DEF  = 2;
    localparam int SHW_DEF  = 3;
    localparam int CNTW_DEF = 16;

    // want_max = 1: 2^(osz-1)-1, want_max = 0: -2^(osz-1)
    function automatic int sat_limit(input int osz, input bit want_max);
        if (want_max) begin
            return (1 << (osz - 1)) - 1;
        end
        return -(1 << (osz - 1));
    endfunction

    // Channel ch of a bus made of w-bit slices starts at bit ch*w
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/sat_round_lane.sv
// ---------------------------------------------------------------------------
// sat_round_lane
//   One channel of the round/shift + saturate datapath.
//   Stage 1: optional round-half-up, arithmetic right shift at ISZ+1 bits,
//            then register the low OSZ bits plus over/under-range flags.
//   Stage 2: select clamp value or pass-through, register result + sat bit.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   ld1, ld2       load enables for stage 1 / stage 2 registers
//   x              signed ISZ-bit input sample
//   shift          right-shift amount for this beat
//   round_en       round-half-up enable for this beat
//   y              signed OSZ-bit output sample
//   sat            1 when y was clamped
// ---------------------------------------------------------------------------
module sat_round_lane
    import sat_round_pipe_pkg::*;
#(
    parameter int ISZ = ISZ_DEF,
    parameter int OSZ = OSZ_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           ld1,
    input  logic           ld2,
    input  logic [ISZ-1:0] x,
    input  logic [SHW-1:0] shift,
    input  logic           round_en,
    output logic [OSZ-1:0] y,
    output logic           sat
);

    localparam logic signed [ISZ:0] HI  = (ISZ + 1)'(sat_limit(OSZ, 1'b1));
    localparam logic signed [ISZ:0] LO  = (ISZ + 1)'(sat_limit(OSZ, 1'b0));
    localparam logic signed [ISZ:0] ONE = (ISZ + 1)'(1);

    logic signed [ISZ:0] xe;
    logic signed [ISZ:0] rc;
    logic signed [ISZ:0] t;

    logic [OSZ-1:0] low1;
    logic           hi1;
    logic           lo1;

    // One extra bit of headroom keeps x + 2^(shift-1) from wrapping.
    always_comb begin
        xe = {x[ISZ-1], x};
        rc = '0;
        if (round_en && (shift != '0)) begin
            rc = ONE << (shift - SHW'(1));
        end
        t = (xe + rc) >>> shift;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            low1 <= '0;
            hi1  <= 1'b0;
            lo1  <= 1'b0;
        end else if (ld1) begin
            low1 <= t[OSZ-1:0];
            hi1  <= (t > HI);
            lo1  <= (t < LO);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (ld2) begin
            if (hi1) begin
                y   <= HI[OSZ-1:0];
                sat <= 1'b1;
            end else if (lo1) begin
                y   <= LO[OSZ-1:0];
                sat <= 1'b1;
            end else begin
                y   <= low1;
                sat <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sat_round_pipe.sv
// ---------------------------------------------------------------------------
// sat_round_pipe
//   Multi-channel two-stage round/shift + saturate pipeline with valid/ready
//   flow control, sticky per-channel saturation flags and saturation counters.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   s_valid/s_ready       input handshake
//   s_data                NCH x ISZ signed samples, channel c at [c*ISZ +: ISZ]
//   shift, round_en       per-beat shift/round settings, captured on accept
//   m_valid/m_ready       output handshake
//   m_data                NCH x OSZ signed samples, channel c at [c*OSZ +: OSZ]
//   sat_flag              sticky "saturated since last clear", per channel
//   sat_count             per-channel saturation event count (CNTW each)
//   stat_clr              single-cycle clear of sat_flag and sat_count
// Build option:
//   SAT_ROUND_PIPE_STATS_EN  defined: saturation counters are built;
//                            undefined: sat_count is constant 0.
// ---------------------------------------------------------------------------
module sat_round_pipe
    import sat_round_pipe_pkg::*;
#(
    parameter int ISZ  = ISZ_DEF,
    parameter int OSZ  = OSZ_DEF,
    parameter int NCH  = NCH_DEF,
    parameter int SHW  = SHW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [NCH*ISZ-1:0]  s_data,
    input  logic [SHW-1:0]      shift,
    input  logic                round_en,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [NCH*OSZ-1:0]  m_data,
    output logic [NCH-1:0]      sat_flag,
    output logic [NCH*CNTW-1:0] sat_count,
    input  logic                stat_clr
);

    // Handshake: a beat moves on a side when valid & ready are both high in
    // the same cycle. Each stage accepts when it is empty or its content
    // leaves in the same cycle, so ready propagates combinationally from
    // m_ready back to s_ready and a stalled pipe holds exactly two beats.
    logic           v1;
    logic           v2;
    logic           ready2;
    logic           ld1;
    logic           ld2;
    logic           fire;
    logic [NCH-1:0] sat2;

    assign ready2  = ~v2 | m_ready;
    assign s_ready = ~v1 | ready2;
    assign ld1     = s_valid & s_ready;
    assign ld2     = v1 & ready2;
    assign m_valid = v2;
    assign fire    = v2 & m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (s_ready) begin
                v1 <= s_valid;
            end
            if (ready2) begin
                v2 <= v1;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        sat_round_lane #(
            .ISZ (ISZ),
            .OSZ (OSZ),
            .SHW (SHW)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .ld1      (ld1),
            .ld2      (ld2),
            .x        (s_data[ch_lsb(c, ISZ) +: ISZ]),
            .shift    (shift),
            .round_en (round_en),
            .y        (m_data[ch_lsb(c, OSZ) +: OSZ]),
            .sat      (sat2[c])
        );
    end

    // stat_clr wins over a coincident saturation event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_flag <= '0;
        end else if (stat_clr) begin
            sat_flag <= '0;
        end else if (fire) begin
            sat_flag <= sat_flag | sat2;
        end
    end

`ifdef SAT_ROUND_PIPE_STATS_EN
    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        logic [CNTW-1:0] cnt;

        // Counter sticks at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt <= '0;
            end else if (stat_clr) begin
                cnt <= '0;
            end else if (fire && sat2[c] && (cnt != '1)) begin
                cnt <= cnt + CNTW'(1);
            end
        end

        assign sat_count[ch_lsb(c, CNTW) +: CNTW] = cnt;
    end
`else
    assign sat_count = '0;
`endif

endmodule
